// File: rtl/vector_writeback_seq_pkg.sv
// Shared types and helpers for the vector writeback sequencer.
// Optional build macro used by this slice: VTAIL_AGNOSTIC_ONES_EN.
package vector_writeback_seq_pkg;

  typedef enum logic [1:0] {
    LMUL_1 = 2'b00,
    LMUL_2 = 2'b01,
    LMUL_4 = 2'b10,
    LMUL_8 = 2'b11
  } lmul_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } vwb_state_e;

  function automatic int unsigned elems_per_reg(input logic [1:0] sew, input int unsigned vlenb);
    return vlenb >> sew;
  endfunction

endpackage

// File: rtl/vector_writeback_seq_byte_en.sv
// Combinational per-byte write-enable generator for one register of an LMUL group.
// With VTAIL_AGNOSTIC_ONES_EN it also flags tail/masked-off bytes to be filled with ones.
module vector_byte_enable_gen
  import vector_writeback_seq_pkg::*;
#(
  parameter int VLEN  = 64,
  parameter int VLENB = VLEN / 8,
  parameter int VLW   = $clog2(VLEN) + 1
) (
  input  logic [2:0]       reg_idx,
  input  sew_e             sew,
  input  logic [VLW-1:0]   vl,
  input  logic             vm,
  input  logic [VLEN-1:0]  v0_snap,
`ifdef VTAIL_AGNOSTIC_ONES_EN
  input  logic             ta,
  input  logic             ma,
  output logic [VLENB-1:0] fill,
`endif
  output logic [VLENB-1:0] enable
);

  localparam int IW = $clog2(VLEN);

  logic [VLW-1:0] epr;
  logic [VLW-1:0] g_idx [VLENB];
  logic [VLENB-1:0] in_body;
  logic [VLENB-1:0] mask_bit;

  // Global element index never exceeds VLEN-1 because a group spans at most 8 registers.
  always_comb begin
    epr      = VLW'(elems_per_reg(sew, VLENB));
    enable   = '0;
    in_body  = '0;
    mask_bit = '0;
`ifdef VTAIL_AGNOSTIC_ONES_EN
    fill     = '0;
`endif
    for (int b = 0; b < VLENB; b++) begin
      g_idx[b]    = VLW'(reg_idx) * epr + (VLW'(b) >> sew);
      in_body[b]  = g_idx[b] < vl;
      mask_bit[b] = vm || v0_snap[g_idx[b][IW-1:0]];
      enable[b]   = in_body[b] && mask_bit[b];
`ifdef VTAIL_AGNOSTIC_ONES_EN
      fill[b]     = (!in_body[b] && ta) || (in_body[b] && !mask_bit[b] && ma);
`endif
    end
  end

endmodule

// File: rtl/vector_writeback_seq.sv
// Writeback sequencer: one register-bank write per accepted LMUL-group beat, with byte enables.
// Optional build macro: VTAIL_AGNOSTIC_ONES_EN (adds ta/ma and all-ones tail/mask fill).
module vector_writeback_seq
  import vector_writeback_seq_pkg::*;
#(
  parameter int VLEN  = 64,
  parameter int VLENB = VLEN / 8,
  parameter int VLW   = $clog2(VLEN) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       vd_base,
  input  logic [1:0]       lmul,
  input  logic [1:0]       sew,
  input  logic [VLW-1:0]   vl,
  input  logic             vm,
  input  logic [VLEN-1:0]  v0_mask,
`ifdef VTAIL_AGNOSTIC_ONES_EN
  input  logic             ta,
  input  logic             ma,
`endif
  input  logic             res_valid,
  input  logic [VLEN-1:0]  res_data,
  output logic             res_ready,
  output logic [VLENB-1:0] enable,
  output logic [4:0]       vd_addr,
  output logic [VLEN-1:0]  result,
  output logic             busy,
  output logic             done
);

  vwb_state_e state, state_nxt;

  logic [2:0]      reg_idx;
  logic [4:0]      vd_base_snap;
  lmul_e           lmul_snap;
  sew_e            sew_snap;
  logic [VLW-1:0]  vl_snap;
  logic            vm_snap;
  logic [VLEN-1:0] v0_snap;

  logic            load;
  logic            accept;
  logic            done_nxt;
  logic [2:0]      last_idx;

  logic [VLENB-1:0] be_active;
  logic [VLENB-1:0] wr_en;
  logic [VLEN-1:0]  wr_data;

  assign last_idx = 3'((4'd1 << lmul_snap) - 4'd1);
  assign busy     = (state == WRITE);

`ifdef VTAIL_AGNOSTIC_ONES_EN
  logic             ta_snap;
  logic             ma_snap;
  logic [VLENB-1:0] be_fill;

  vector_byte_enable_gen #(.VLEN(VLEN), .VLENB(VLENB), .VLW(VLW)) u_be_gen (
    .reg_idx (reg_idx),
    .sew     (sew_snap),
    .vl      (vl_snap),
    .vm      (vm_snap),
    .v0_snap (v0_snap),
    .ta      (ta_snap),
    .ma      (ma_snap),
    .fill    (be_fill),
    .enable  (be_active)
  );

  always_comb begin
    wr_en = be_active | be_fill;
    for (int b = 0; b < VLENB; b++) begin
      wr_data[8*b +: 8] = be_fill[b] ? 8'hFF : res_data[8*b +: 8];
    end
  end
`else
  vector_byte_enable_gen #(.VLEN(VLEN), .VLENB(VLENB), .VLW(VLW)) u_be_gen (
    .reg_idx (reg_idx),
    .sew     (sew_snap),
    .vl      (vl_snap),
    .vm      (vm_snap),
    .v0_snap (v0_snap),
    .enable  (be_active)
  );

  assign wr_en   = be_active;
  assign wr_data = res_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    res_ready = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (vl == '0) begin
            done_nxt = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        res_ready = 1'b1;
        accept    = res_valid;
        if (res_valid && (reg_idx == last_idx)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write stage: the accepted beat lands on the bank port one cycle after the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_idx      <= '0;
      vd_base_snap <= '0;
      lmul_snap    <= LMUL_1;
      sew_snap     <= SEW_8;
      vl_snap      <= '0;
      vm_snap      <= 1'b0;
      v0_snap      <= '0;
`ifdef VTAIL_AGNOSTIC_ONES_EN
      ta_snap      <= 1'b0;
      ma_snap      <= 1'b0;
`endif
      enable       <= '0;
      vd_addr      <= '0;
      result       <= '0;
      done         <= 1'b0;
    end else begin
      done   <= done_nxt;
      enable <= '0;
      if (load) begin
        reg_idx      <= '0;
        vd_base_snap <= vd_base;
        lmul_snap    <= lmul_e'(lmul);
        sew_snap     <= sew_e'(sew);
        vl_snap      <= vl;
        vm_snap      <= vm;
        v0_snap      <= v0_mask;
`ifdef VTAIL_AGNOSTIC_ONES_EN
        ta_snap      <= ta;
        ma_snap      <= ma;
`endif
      end
      if (accept) begin
        enable  <= wr_en;
        vd_addr <= vd_base_snap + 5'(reg_idx);
        result  <= wr_data;
        reg_idx <= reg_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_vector_writeback_seq.sv
// Directed self-checking bench for vector_writeback_seq (VLEN=64).
module tb_vector_writeback_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  vd_base;
  logic [1:0]  lmul;
  logic [1:0]  sew;
  logic [6:0]  vl;
  logic        vm;
  logic [63:0] v0_mask;
`ifdef VTAIL_AGNOSTIC_ONES_EN
  logic        ta;
  logic        ma;
`endif
  logic        res_valid;
  logic [63:0] res_data;
  logic        res_ready;
  logic [7:0]  enable;
  logic [4:0]  vd_addr;
  logic [63:0] result;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  vector_writeback_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .vd_base   (vd_base),
    .lmul      (lmul),
    .sew       (sew),
    .vl        (vl),
    .vm        (vm),
    .v0_mask   (v0_mask),
`ifdef VTAIL_AGNOSTIC_ONES_EN
    .ta        (ta),
    .ma        (ma),
`endif
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .enable    (enable),
    .vd_addr   (vd_addr),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; all driving and sampling happens there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] b, input logic [1:0] l, input logic [1:0] s,
                          input logic [6:0] n, input logic m, input logic [63:0] v0);
    vd_base = b; lmul = l; sew = s; vl = n; vm = m; v0_mask = v0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; vd_base = '0; lmul = '0; sew = '0; vl = '0; vm = 1'b1;
    v0_mask = '0; res_valid = 1'b0; res_data = '0;
`ifdef VTAIL_AGNOSTIC_ONES_EN
    ta = 1'b0; ma = 1'b0;
`endif
    tick(); tick();
    checks++; if ({enable, vd_addr, result} !== 77'd0) begin errors++;
      $display("FAIL reset_outputs: got en=%h addr=%0d res=%h want 0", enable, vd_addr, result); end
    checks++; if ({res_ready, busy, done} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: got ready/busy/done=%b want 000", {res_ready, busy, done}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_start(5'd3, 2'b00, 2'b00, 7'd5, 1'b1, 64'd0);
    checks++; if ({busy, res_ready, enable} !== {2'b11, 8'h00}) begin errors++;
      $display("FAIL single_busy: got busy=%b ready=%b en=%h want 1 1 00", busy, res_ready, enable); end
    res_valid = 1'b1; res_data = 64'h1122334455667788;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'h1F) begin errors++;
      $display("FAIL single_en: got %h want 1f", enable); end
    checks++; if (vd_addr !== 5'd3 || result !== 64'h1122334455667788) begin errors++;
      $display("FAIL single_write: got addr=%0d res=%h want 3 1122334455667788", vd_addr, result); end
    checks++; if ({done, busy} !== 2'b10) begin errors++;
      $display("FAIL single_done: got done/busy=%b want 10", {done, busy}); end
    tick();
    checks++; if ({done, enable} !== 9'd0) begin errors++;
      $display("FAIL single_after: got done=%b en=%h want 0 00", done, enable); end
  endtask

  task automatic test_masked();
    do_start(5'd10, 2'b01, 2'b01, 7'd6, 1'b0, 64'b101101);
    v0_mask = '1;
    res_valid = 1'b1; res_data = 64'hA0A1A2A3A4A5A6A7;
    tick();
    checks++; if (enable !== 8'hF3 || vd_addr !== 5'd10 || done !== 1'b0) begin errors++;
      $display("FAIL masked_beat0: got en=%h addr=%0d done=%b want f3 10 0", enable, vd_addr, done); end
    res_data = 64'hB0B1B2B3B4B5B6B7;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'h0C || vd_addr !== 5'd11 || result !== 64'hB0B1B2B3B4B5B6B7) begin errors++;
      $display("FAIL masked_beat1: got en=%h addr=%0d res=%h want 0c 11 b0b1b2b3b4b5b6b7", enable, vd_addr, result); end
    checks++; if (done !== 1'b1) begin errors++;
      $display("FAIL masked_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_wrap();
    logic [4:0] exp_addr [4];
    exp_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
    do_start(5'd30, 2'b10, 2'b10, 7'd8, 1'b1, 64'd0);
    res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_data = 64'h0101010101010101 * (i + 1);
      tick();
      checks++; if (vd_addr !== exp_addr[i] || enable !== 8'hFF || done !== (i == 3)) begin errors++;
        $display("FAIL wrap_beat%0d: got addr=%0d en=%h done=%b want %0d ff %0d",
                 i, vd_addr, enable, done, exp_addr[i], (i == 3)); end
    end
    res_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_start(5'd4, 2'b00, 2'b11, 7'd1, 1'b1, 64'd0);
    res_valid = 1'b1; res_data = 64'hCAFE;
    tick();
    res_valid = 1'b0;
    checks++; if (done !== 1'b1 || enable !== 8'hFF || vd_addr !== 5'd4) begin errors++;
      $display("FAIL b2b_first: got done=%b en=%h addr=%0d want 1 ff 4", done, enable, vd_addr); end
    do_start(5'd7, 2'b00, 2'b00, 7'd2, 1'b1, 64'd0);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL b2b_restart: got busy=%b want 1", busy); end
    res_valid = 1'b1; res_data = 64'hBEEF;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'h03 || vd_addr !== 5'd7 || done !== 1'b1) begin errors++;
      $display("FAIL b2b_second: got en=%h addr=%0d done=%b want 03 7 1", enable, vd_addr, done); end
    tick();
  endtask

  task automatic test_stall_and_abort();
    do_start(5'd5, 2'b01, 2'b00, 7'd16, 1'b1, 64'd0);
    res_valid = 1'b1; res_data = 64'h1;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'hFF || vd_addr !== 5'd5) begin errors++;
      $display("FAIL stall_beat0: got en=%h addr=%0d want ff 5", enable, vd_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (enable !== 8'h00 || busy !== 1'b1 || done !== 1'b0) begin errors++;
        $display("FAIL stall_gap%0d: got en=%h busy=%b done=%b want 00 1 0", i, enable, busy, done); end
    end
    res_valid = 1'b1; res_data = 64'h2;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'hFF || vd_addr !== 5'd6 || done !== 1'b1) begin errors++;
      $display("FAIL stall_beat1: got en=%h addr=%0d done=%b want ff 6 1", enable, vd_addr, done); end
    tick();
    do_start(5'd12, 2'b01, 2'b00, 7'd16, 1'b1, 64'd0);
    res_valid = 1'b1; res_data = 64'h3;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'hFF || vd_addr !== 5'd12) begin errors++;
      $display("FAIL abort_beat0: got en=%h addr=%0d want ff 12", enable, vd_addr); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || enable !== 8'h00 || res_ready !== 1'b0) begin errors++;
      $display("FAIL abort_reset: got busy=%b en=%h ready=%b want 0 00 0", busy, enable, res_ready); end
    #2 reset_n = 1'b1;
    res_valid = 1'b1; res_data = 64'h4;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_after: got en=%h done=%b busy=%b want 00 0 0", enable, done, busy); end
    tick();
  endtask

  task automatic test_zero_vl_and_ignore();
    res_valid = 1'b1; res_data = 64'h5;
    do_start(5'd9, 2'b01, 2'b00, 7'd0, 1'b1, 64'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || res_ready !== 1'b0) begin errors++;
      $display("FAIL zero_vl_done: got done=%b busy=%b ready=%b want 1 0 0", done, busy, res_ready); end
    tick();
    checks++; if (done !== 1'b0 || res_ready !== 1'b0 || enable !== 8'h00) begin errors++;
      $display("FAIL zero_vl_after: got done=%b ready=%b en=%h want 0 0 00", done, res_ready, enable); end
    res_valid = 1'b0;
    do_start(5'd2, 2'b00, 2'b00, 7'd8, 1'b1, 64'd0);
    do_start(5'd20, 2'b00, 2'b00, 7'd1, 1'b1, 64'd0);
    res_valid = 1'b1; res_data = 64'h6;
    tick();
    res_valid = 1'b0;
    checks++; if (vd_addr !== 5'd2 || enable !== 8'hFF || done !== 1'b1) begin errors++;
      $display("FAIL ignore_start: got addr=%0d en=%h done=%b want 2 ff 1", vd_addr, enable, done); end
    tick();
  endtask

`ifdef VTAIL_AGNOSTIC_ONES_EN
  task automatic test_agnostic();
    ta = 1'b1; ma = 1'b0;
    do_start(5'd1, 2'b00, 2'b00, 7'd3, 1'b1, 64'd0);
    res_valid = 1'b1; res_data = 64'd0;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'hFF || result !== 64'hFFFFFFFFFF000000) begin errors++;
      $display("FAIL agn_tail: got en=%h res=%h want ff ffffffffff000000", enable, result); end
    tick();
    ta = 1'b0; ma = 1'b1;
    do_start(5'd1, 2'b00, 2'b00, 7'd8, 1'b0, 64'b101);
    res_valid = 1'b1; res_data = 64'd0;
    tick();
    res_valid = 1'b0;
    checks++; if (enable !== 8'hFF || result !== 64'hFFFFFFFFFF00FF00) begin errors++;
      $display("FAIL agn_mask: got en=%h res=%h want ff ffffffffff00ff00", enable, result); end
    ma = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_masked();
    test_wrap();
    test_back_to_back();
    test_stall_and_abort();
    test_zero_vl_and_ignore();
`ifdef VTAIL_AGNOSTIC_ONES_EN
    test_agnostic();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_writeback_seq.md
Name: vector_writeback_seq

Overview:
- Writeback sequencer between the vector execute unit and the vector register bank write port (enable / vd_addr / result).
- Accepts one VLEN-bit result beat per register of an LMUL group.
- For each beat it computes per-byte write enables from vl, SEW, LMUL, vm and a snapshot of v0, then drives one register-bank write per beat.
- Handles LMUL group address stepping and emits a completion pulse.

Parameters:
- VLEN, 64, vector register width in bits.
- VLENB, 8, VLEN/8; number of byte lanes and the width of enable.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a writeback sequence; sampled only in IDLE.
- vd_base  in  5  first destination register of the group.
- lmul  in  2  group size: 00=1, 01=2, 10=4, 11=8.
- sew  in  2  element width: 00=8, 01=16, 10=32, 11=64 bits.
- vl  in  $clog2(VLEN)+1  active element count, 0..VLEN.
- vm  in  1  1 = unmasked, 0 = masked by v0.
- v0_mask  in  VLEN  live v0 contents from the register bank.
- res_valid  in  1  execute result beat valid.
- res_data  in  VLEN  result beat; one full register per beat.
- res_ready  out  1  beat accepted when res_valid && res_ready.
- enable  out  VLENB  byte write enables to the register bank.
- vd_addr  out  5  register bank write address.
- result  out  VLEN  register bank write data.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: enable=0, vd_addr=0, result=0, res_ready=0, busy=0, done=0. The FSM goes to IDLE and all counters and snapshots clear.
- FSM states: IDLE, WRITE.
- IDLE + start, vl != 0:
  - Latch vd_base, lmul, sew, vl, vm and v0_mask (snapshot; later writes to v0 do not affect this sequence).
  - Set reg_idx=0, go to WRITE. busy=1 from the next cycle.
- IDLE + start, vl == 0: done pulses the next cycle, no beats are accepted, busy stays 0.
- start while busy is ignored.
- WRITE:
  - res_ready=1 combinationally.
  - On acceptance, the next cycle presents vd_addr = (vd_base + reg_idx) mod 32 (5-bit wrap), result=res_data and enable=computed mask. reg_idx then increments.
  - enable is 0 in every cycle that has no accepted beat the cycle before.
- Byte enables:
  - epr = VLENB >> sew.
  - For byte b, element e = b >> sew and global index g = reg_idx*epr + e.
  - Byte is enabled iff g < vl and (vm || v0_snap[g]).
  - Enables are computed with the latched fields only.
- Completion and latency:
  - The final beat (reg_idx == 2^lmul - 1) is accepted, then the FSM returns to IDLE.
  - done=1 and the last write appear in the same cycle, one cycle after acceptance. busy drops in that same cycle.
  - A new start is accepted in the cycle done is high (FSM already IDLE).
  - Beats beyond vl are still consumed with enable=0; the group always takes exactly 2^lmul beats.
- res_valid gaps stall reg_idx, with no timeout.
- Reset mid-operation aborts immediately. A sequence in flight produces no further writes and no done.

Optional Feature:
- Macro: VTAIL_AGNOSTIC_ONES_EN.
- With the macro:
  - Extra inputs ta and ma (1 bit each) are latched at start.
  - Tail bytes (g >= vl) when ta=1, and masked-off bytes when ma=1, are written with all-ones (enable=1, data byte 0xFF).
- Without the macro: the ports are absent, and tail/masked bytes are left undisturbed (enable=0).

Decomposition:
- Shared package:
  - lmul_e and sew_e enums.
  - vwb_state_e {IDLE, WRITE}.
  - Function elems_per_reg(sew, VLENB).
- One sub-module, vector_byte_enable_gen: purely combinational. It maps (reg_idx, sew, vl, vm, v0_snap) to enable[VLENB-1:0]; the macro variant also outputs an agnostic-fill mask.

Test Plan:
1. vd_base=3, lmul=00, sew=00, vl=5, vm=1, beat 0x1122334455667788 -> next cycle enable=0x1F, vd_addr=3, result=0x1122334455667788, done=1.
2. lmul=01, sew=01, vl=6, vm=0, v0=0b101101 -> beat0 enable=0xF3, beat1 enable=0x0C, addresses vd_base and vd_base+1; v0 changed after start has no effect.
3. vd_base=30, lmul=10, sew=10, vl=8, vm=1 -> four writes to 30, 31, 0, 1, each with enable=0xFF; done with the 4th write.
4. lmul=01 with res_valid low for 3 cycles between beats -> enable=0 in the gap cycles, exactly 2 writes. Reset asserted after beat 1 -> busy=0, no done, no second write.
5. start with vl=0 -> done pulses next cycle, res_ready never high. start while busy -> ignored, latched fields unchanged.
6. With VTAIL_AGNOSTIC_ONES_EN, sew=00, vl=3, ta=1, beat all zeros -> enable=0xFF, result=0xFFFFFFFFFF000000.
